// File: rtl/board_neighbor_counter_pkg.sv
// Shared types for the board neighbour counter: cell fields,
// neighbour offset table and FSM state encodings.
package board_neighbor_counter_pkg;

  localparam int BOARD_EDGE_MAX = 16;

  localparam int FIELD_MINE_BIT = 0;
  localparam int FIELD_CNT_LSB  = 1;
  localparam int FIELD_CNT_W    = 4;

  typedef logic [7:0] field_t;

  typedef logic signed [1:0] off_t;

  // Neighbour visiting order, row-major around the centre cell
  localparam off_t NBR_DR [8] = '{
    -2'sd1, -2'sd1, -2'sd1, 2'sd0,
    2'sd0, 2'sd1, 2'sd1, 2'sd1
  };
  localparam off_t NBR_DC [8] = '{
    -2'sd1, 2'sd0, 2'sd1, -2'sd1,
    2'sd1, -2'sd1, 2'sd0, 2'sd1
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD_CELL,
    S_RD_NBR,
    S_WR,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_STB,
    X_WAIT
  } xfer_t;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone link between one master and the board memory.
// Byte-wide data, 8-bit {row,col} address.
interface wishbone_if;
  logic [7:0] adr_o;
  logic [7:0] dat_o;
  logic       we_o;
  logic       stb_o;
  logic       cyc_o;
  logic       stall_i;
  logic       ack_i;
  logic [7:0] dat_i;

  modport master (
    output adr_o, dat_o, we_o, stb_o, cyc_o,
    input  stall_i, ack_i, dat_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, stb_o, cyc_o,
    output stall_i, ack_i, dat_i
  );
endinterface

// File: rtl/wb_single_xfer.sv
// Single-transaction Wishbone master: holds stb through stall,
// then keeps cyc up until the ack, one transfer outstanding.
module wb_single_xfer
  import board_neighbor_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] adr,
  input  field_t     dat,
  output logic       ack,
  output field_t     rdata,
  wishbone_if.master bus
);

  xfer_t ph, ph_n;
  logic [7:0] adr_q;
  field_t dat_q;
  logic we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ph <= X_IDLE;
    else     ph <= ph_n;
  end

  always_comb begin
    ph_n = ph;
    unique case (ph)
      X_IDLE:  if (req)          ph_n = X_STB;
      X_STB:   if (!bus.stall_i) ph_n = X_WAIT;
      X_WAIT:  if (bus.ack_i)    ph_n = X_IDLE;
      default:                   ph_n = X_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
    end else if (ph == X_IDLE && req) begin
      adr_q <= adr;
      dat_q <= dat;
      we_q  <= we;
    end
  end

  assign bus.cyc_o = (ph != X_IDLE);
  assign bus.stb_o = (ph == X_STB);
  assign bus.we_o  = we_q & (ph != X_IDLE);
  assign bus.adr_o = adr_q;
  assign bus.dat_o = dat_q;

  assign ack   = (ph == X_WAIT) & bus.ack_i;
  assign rdata = bus.dat_i;

endmodule

// File: rtl/board_neighbor_counter.sv
// Scans the board, writes each non-mine cell's neighbour mine count.
// Define BOARD_NBR_MINE_TOTAL_EN to add the mine_total output.
module board_neighbor_counter
  import board_neighbor_counter_pkg::*;
#(
  parameter int BOARD_SIZE = BOARD_EDGE_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] active_size,
  output logic       busy,
  output logic       done,
  wishbone_if.master master_w,
  wishbone_if.master master_r
`ifdef BOARD_NBR_MINE_TOTAL_EN
  ,
  output logic [8:0] mine_total
`endif
);

  state_t state, state_n;
  logic [4:0] row, col, size;
  logic [2:0] nbr_idx;
  logic [3:0] cnt;
  logic [2:0] keep_q;
  off_t dr, dc;
  logic [5:0] nr, nc;
  logic nbr_ok, col_last, row_last;
  logic rd_req, rd_ack, wr_req, wr_ack;
  logic [7:0] rd_adr, wr_adr;
  field_t rd_data, wr_dat, unused_wr_data;
  logic [3:0] unused_rd_mid;
  logic [4:0] size_in;

  assign size_in =
    (active_size < 5'd2 || active_size > 5'(BOARD_SIZE))
    ? 5'(BOARD_SIZE) : active_size;

  // Sign-extended add; a negative result sets bit 5
  assign dr = NBR_DR[nbr_idx];
  assign dc = NBR_DC[nbr_idx];
  assign nr = {1'b0, row} + {{4{dr[1]}}, dr};
  assign nc = {1'b0, col} + {{4{dc[1]}}, dc};
  assign nbr_ok = !nr[5] && !nc[5] &&
                  (nr[4:0] < size) && (nc[4:0] < size);

  assign col_last = (col + 5'd1) == size;
  assign row_last = (row + 5'd1) == size;

  assign wr_adr = {row[3:0], col[3:0]};
  assign wr_dat = {keep_q, cnt, 1'b0};
  assign unused_rd_mid = rd_data[4:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_adr  = {row[3:0], col[3:0]};
    unique case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: state_n = S_RD_CELL;
      S_RD_CELL: begin
        rd_req = 1'b1;
        if (rd_ack)
          state_n = rd_data[FIELD_MINE_BIT] ? S_NEXT : S_RD_NBR;
      end
      S_RD_NBR: begin
        rd_adr = {nr[3:0], nc[3:0]};
        rd_req = nbr_ok;
        if ((!nbr_ok || rd_ack) && nbr_idx == 3'd7)
          state_n = S_WR;
      end
      S_WR: begin
        wr_req = 1'b1;
        if (wr_ack) state_n = S_NEXT;
      end
      S_NEXT:
        state_n = (col_last && row_last) ? S_DONE : S_RD_CELL;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      size    <= 5'(BOARD_SIZE);
      nbr_idx <= '0;
      cnt     <= '0;
      keep_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          size <= size_in;
          row  <= '0;
          col  <= '0;
        end
        S_RD_CELL: if (rd_ack) begin
          keep_q  <= rd_data[7:5];
          cnt     <= '0;
          nbr_idx <= '0;
        end
        S_RD_NBR: if (!nbr_ok || rd_ack) begin
          nbr_idx <= nbr_idx + 3'd1;
          if (rd_ack) cnt <= cnt + {3'b0, rd_data[FIELD_MINE_BIT]};
        end
        S_NEXT: if (col_last) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOARD_NBR_MINE_TOTAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mine_total <= '0;
    else if (state == S_IDLE && start)
      mine_total <= '0;
    else if (state == S_RD_CELL && rd_ack && rd_data[FIELD_MINE_BIT])
      mine_total <= mine_total + 9'd1;
  end
`endif

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  wb_single_xfer u_rd (
    .clk   (clk),
    .rst   (rst),
    .req   (rd_req),
    .we    (1'b0),
    .adr   (rd_adr),
    .dat   (8'h00),
    .ack   (rd_ack),
    .rdata (rd_data),
    .bus   (master_r)
  );

  wb_single_xfer u_wr (
    .clk   (clk),
    .rst   (rst),
    .req   (wr_req),
    .we    (1'b1),
    .adr   (wr_adr),
    .dat   (wr_dat),
    .ack   (wr_ack),
    .rdata (unused_wr_data),
    .bus   (master_w)
  );

endmodule

// File: tb/tb_board_neighbor_counter.sv
// Bench for board_neighbor_counter: memory slave with random stalls,
// reference board model, per-scenario checks.
module tb_board_neighbor_counter;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [4:0] active_size;
  logic busy, done;
`ifdef BOARD_NBR_MINE_TOTAL_EN
  logic [8:0] mine_total;
`endif

  wishbone_if wb_w ();
  wishbone_if wb_r ();

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] init_mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] board [256];
  int exp_rd, exp_wr, exp_mines;
  int rd_cnt, wr_cnt, done_cnt;
  bit viol_overlap, viol_stable, viol_oob, viol_mine_wr, viol_we;
  int smax = 0;
  int cur_size = 16;
  int r_st = 0;
  int w_st = 0;
  bit r_hold, w_hold;
  logic [7:0] r_adr_h, w_adr_h, w_dat_h;

  always #5 clk = ~clk;

  board_neighbor_counter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .active_size (active_size),
    .busy        (busy),
    .done        (done),
    .master_w    (wb_w),
    .master_r    (wb_r)
`ifdef BOARD_NBR_MINE_TOTAL_EN
    ,
    .mine_total  (mine_total)
`endif
  );

  // Memory slave: accept on stb && !stall, ack next cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_r.ack_i <= 1'b0;
      wb_w.ack_i <= 1'b0;
      wb_r.stall_i <= 1'b0;
      wb_w.stall_i <= 1'b0;
      wb_r.dat_i <= 8'h00;
      wb_w.dat_i <= 8'h00;
      r_st = 0;
      w_st = 0;
    end else begin
      wb_r.ack_i <= 1'b0;
      wb_w.ack_i <= 1'b0;
      if (wb_r.cyc_o && wb_r.stb_o) begin
        if (!wb_r.stall_i) begin
          wb_r.ack_i <= 1'b1;
          wb_r.dat_i <= mem[wb_r.adr_o];
          rd_cnt++;
          if (wb_r.we_o) viol_we = 1;
          if (int'(wb_r.adr_o[7:4]) >= cur_size ||
              int'(wb_r.adr_o[3:0]) >= cur_size) viol_oob = 1;
          r_st = int'($urandom_range(smax));
          wb_r.stall_i <= (r_st != 0);
          w_st = 1 + int'($urandom_range(smax));
          wb_w.stall_i <= 1'b1;
        end else begin
          r_st--;
          wb_r.stall_i <= (r_st > 0);
        end
      end
      if (wb_w.cyc_o && wb_w.stb_o) begin
        if (!wb_w.stall_i) begin
          wb_w.ack_i <= 1'b1;
          mem[wb_w.adr_o] = wb_w.dat_o;
          wr_cnt++;
          if (!wb_w.we_o) viol_we = 1;
          if (init_mem[wb_w.adr_o][0]) viol_mine_wr = 1;
          w_st = int'($urandom_range(smax));
          wb_w.stall_i <= (w_st != 0);
        end else begin
          w_st--;
          wb_w.stall_i <= (w_st > 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      r_hold = 0;
      w_hold = 0;
    end else begin
      if (wb_r.cyc_o && wb_w.cyc_o) viol_overlap = 1;
      if (done) done_cnt++;
      if (r_hold && (!wb_r.stb_o || wb_r.adr_o != r_adr_h))
        viol_stable = 1;
      if (w_hold && (!wb_w.stb_o || !wb_w.we_o ||
          wb_w.adr_o != w_adr_h || wb_w.dat_o != w_dat_h))
        viol_stable = 1;
      r_hold = wb_r.stb_o && wb_r.stall_i;
      w_hold = wb_w.stb_o && wb_w.stall_i;
      r_adr_h = wb_r.adr_o;
      w_adr_h = wb_w.adr_o;
      w_dat_h = wb_w.dat_o;
    end
  end

  // Expected board from the game rules, plus bus traffic totals
  task automatic build_model(input int n);
    logic [7:0] v;
    int m, rr, cc;
    exp_rd = 0;
    exp_wr = 0;
    exp_mines = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_mem[i];
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        v = init_mem[r*16 + c];
        exp_rd++;
        if (v[0]) begin
          exp_mines++;
        end else begin
          m = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              rr = r + dr;
              cc = c + dc;
              if ((dr != 0 || dc != 0) && rr >= 0 && cc >= 0 &&
                  rr < n && cc < n) begin
                exp_rd++;
                m += int'(init_mem[rr*16 + cc][0]);
              end
            end
          end
          exp_mem[r*16 + c] = {v[7:5], 4'(m), 1'b0};
          exp_wr++;
        end
      end
    end
  endtask

  function automatic int count_bad();
    int b = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== exp_mem[i]) b++;
    return b;
  endfunction

  task automatic fill_random(input int pct);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      v[0] = ($urandom_range(99) < pct);
      mem[i] = v;
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    viol_overlap = 0;
    viol_stable = 0;
    viol_oob = 0;
    viol_mine_wr = 0;
    viol_we = 0;
  endtask

  task automatic run_scan(input logic [4:0] asz, input int n,
                          input int sm, input int restart_at,
                          output bit seen);
    smax = sm;
    cur_size = n;
    for (int i = 0; i < 256; i++) init_mem[i] = mem[i];
    build_model(n);
    clear_stats();
    @(negedge clk);
    start = 1'b1;
    active_size = asz;
    @(negedge clk);
    start = 1'b0;
    active_size = 5'($urandom);
    seen = 0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
      if (i == restart_at) begin
        start = 1'b1;
        active_size = 5'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    active_size = 5'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: got %b expected 00", {busy, done});
    end
    checks++;
    if ({wb_r.cyc_o, wb_r.stb_o, wb_r.we_o,
         wb_w.cyc_o, wb_w.stb_o, wb_w.we_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 000000",
        {wb_r.cyc_o, wb_r.stb_o, wb_r.we_o,
         wb_w.cyc_o, wb_w.stb_o, wb_w.we_o});
    end
    checks++;
    if ({wb_r.adr_o, wb_w.adr_o, wb_w.dat_o} !== 24'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h expected 000000",
        {wb_r.adr_o, wb_w.adr_o, wb_w.dat_o});
    end
  endtask

  task automatic test_single_mine();
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h1E;
    mem[8'h00] = 8'h01;
    run_scan(5'd4, 4, 0, -1, seen);
    checks++;
    if (!seen || done_cnt != 1) begin
      errors++;
      $display("FAIL single_done: got seen=%0d pulses=%0d expected 1 1",
        seen, done_cnt);
    end
    checks++;
    if (wr_cnt != 15 || rd_cnt != exp_rd) begin
      errors++;
      $display("FAIL single_traffic: got wr=%0d rd=%0d expected 15 %0d",
        wr_cnt, rd_cnt, exp_rd);
    end
    checks++;
    if ({mem[8'h01], mem[8'h10], mem[8'h11], mem[8'h33]} !== 32'h02020200)
    begin
      errors++;
      $display("FAIL single_cells: got %h %h %h %h expected 02 02 02 00",
        mem[8'h01], mem[8'h10], mem[8'h11], mem[8'h33]);
    end
    checks++;
    if (mem[8'h00] !== 8'h01 || viol_mine_wr || count_bad() != 0) begin
      errors++;
      $display("FAIL single_board: got cell0=%h minewr=%0d bad=%0d expected 01 0 0",
        mem[8'h00], viol_mine_wr, count_bad());
    end
  endtask

  task automatic test_center_mine();
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h1E;
    mem[8'h11] = 8'h01;
    run_scan(5'd3, 3, 0, -1, seen);
    checks++;
    if (!seen || wr_cnt != 8) begin
      errors++;
      $display("FAIL center_writes: got seen=%0d wr=%0d expected 1 8",
        seen, wr_cnt);
    end
    checks++;
    if (viol_oob) begin
      errors++;
      $display("FAIL center_oob: got read outside 3x3 expected none");
    end
    checks++;
    if (count_bad() != 0 || mem[8'h22] !== 8'h02) begin
      errors++;
      $display("FAIL center_board: got bad=%0d cell22=%h expected 0 02",
        count_bad(), mem[8'h22]);
    end
  endtask

  task automatic test_all_mines();
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    run_scan(5'd3, 3, 0, -1, seen);
    checks++;
    if (!seen || done_cnt != 1 || rd_cnt != 9 || wr_cnt != 0) begin
      errors++;
      $display("FAIL all_mines: got seen=%0d done=%0d rd=%0d wr=%0d expected 1 1 9 0",
        seen, done_cnt, rd_cnt, wr_cnt);
    end
`ifdef BOARD_NBR_MINE_TOTAL_EN
    checks++;
    if (mine_total !== 9'(exp_mines)) begin
      errors++;
      $display("FAIL all_mines_total: got %0d expected %0d",
        mine_total, exp_mines);
    end
`endif
  endtask

  task automatic test_preserve();
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hE1;
    mem[8'h01] = 8'hA0;
    mem[8'h11] = 8'h01;
    run_scan(5'd3, 3, 0, -1, seen);
    checks++;
    if (!seen || mem[8'h00] !== 8'hE1 || mem[8'h01] !== 8'hA4) begin
      errors++;
      $display("FAIL preserve: got %h %h expected E1 A4",
        mem[8'h00], mem[8'h01]);
    end
    checks++;
    if (count_bad() != 0) begin
      errors++;
      $display("FAIL preserve_board: got %0d bad cells expected 0",
        count_bad());
    end
  endtask

  task automatic test_random_stall();
    bit seen;
    int diff;
    fill_random(20);
    for (int i = 0; i < 256; i++) board[i] = mem[i];
    run_scan(5'd20, 16, 0, -1, seen);
    checks++;
    if (!seen || count_bad() != 0 || rd_cnt != exp_rd ||
        wr_cnt != exp_wr) begin
      errors++;
      $display("FAIL nostall_run: got seen=%0d bad=%0d rd=%0d wr=%0d expected 1 0 %0d %0d",
        seen, count_bad(), rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = mem[i];
      mem[i] = board[i];
    end
    run_scan(5'd16, 16, 5, -1, seen);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    checks++;
    if (!seen || count_bad() != 0 || diff != 0) begin
      errors++;
      $display("FAIL stall_run: got seen=%0d bad=%0d diff=%0d expected 1 0 0",
        seen, count_bad(), diff);
    end
    checks++;
    if (viol_stable || viol_overlap || viol_we || viol_mine_wr) begin
      errors++;
      $display("FAIL stall_protocol: got stable=%0d overlap=%0d we=%0d minewr=%0d expected 0 0 0 0",
        viol_stable, viol_overlap, viol_we, viol_mine_wr);
    end
`ifdef BOARD_NBR_MINE_TOTAL_EN
    checks++;
    if (mine_total !== 9'(exp_mines)) begin
      errors++;
      $display("FAIL stall_total: got %0d expected %0d",
        mine_total, exp_mines);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    fill_random(25);
    for (int i = 0; i < 256; i++) init_mem[i] = mem[i];
    smax = 3;
    cur_size = 16;
    clear_stats();
    @(negedge clk);
    start = 1'b1;
    active_size = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b expected 1", busy);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, wb_r.cyc_o, wb_r.stb_o, wb_w.cyc_o, wb_w.stb_o,
         wb_w.we_o} !== 7'b0 ||
        {wb_r.adr_o, wb_w.adr_o, wb_w.dat_o} !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset: got %b %h expected 0000000 000000",
        {busy, done, wb_r.cyc_o, wb_r.stb_o, wb_w.cyc_o, wb_w.stb_o,
         wb_w.we_o}, {wb_r.adr_o, wb_w.adr_o, wb_w.dat_o});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan(5'd0, 16, 0, 200, seen);
    checks++;
    if (!seen || done_cnt != 1 || count_bad() != 0) begin
      errors++;
      $display("FAIL rescan: got seen=%0d done=%0d bad=%0d expected 1 1 0",
        seen, done_cnt, count_bad());
    end
    checks++;
    if (rd_cnt != exp_rd || wr_cnt != exp_wr) begin
      errors++;
      $display("FAIL rescan_traffic: got rd=%0d wr=%0d expected %0d %0d",
        rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  initial begin
    test_reset();
    test_single_mine();
    test_center_mine();
    test_all_mines();
    test_preserve();
    test_random_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
